// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size encodings, FSM states and lane helpers shared by the
// load/store unit and its bench.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } lsu_state_e;

    localparam int LOAD_LATENCY = 2;

    // Byte lanes touched by an aligned access of the given size at offset off.
    function automatic logic [3:0] lane_en(input mem_size_e size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off :
               size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/bram_sp_be.sv
// bram_sp_be: single-port 32-bit block RAM with per-byte write enables and a
// registered read-first output.
module bram_sp_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [3:0]               i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_din,
    output logic [31:0]              o_dout
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++)
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_din[8*b +: 8];
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable load/store unit over a single-port block RAM,
// with a post-reset zero-fill pass and a fixed two-cycle response pipeline.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam lsu_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    lsu_state_e    r_state, w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    mem_size_e     w_size;
    logic          w_accept, w_err, w_clearing, w_bram_en;
    logic [3:0]    w_bram_be;
    logic [AW-1:0] w_bram_addr;
    logic [31:0]   w_bram_din, w_bram_dout, w_ext;
    logic [15:0]   w_lane;

    logic          r_s1_valid, r_s1_load, r_s1_err, r_s1_uns;
    mem_size_e     r_s1_size;
    logic [1:0]    r_s1_off;
    logic          r_rsp_valid, r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    assign w_size     = mem_size_e'(req_size);
    assign w_clearing = r_state == ST_CLEAR;
    assign req_ready  = rst_n && r_state == ST_READY;
    assign w_accept   = req_valid && req_ready;
    assign w_err      = w_size == SZ_ILL || (w_size == SZ_HALF && req_addr[0]) ||
                        (w_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                        64'(req_addr) >= 64'(4 * DEPTH_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clearing ? r_clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clearing && r_clr_cnt == AW'(DEPTH_WORDS - 1)) w_state_nxt = ST_READY;
    end

    // The zero-fill pass owns the RAM port; errored requests never touch it.
    assign w_bram_en   = w_clearing || (w_accept && !w_err);
    assign w_bram_addr = w_clearing ? r_clr_cnt : req_addr[AW+1:2];
    assign w_bram_be   = w_clearing ? 4'hF :
                         (w_accept && req_we && !w_err) ? lane_en(w_size, req_addr[1:0]) : 4'h0;
    assign w_bram_din  = w_clearing ? '0 :
                         w_size == SZ_BYTE ? {4{req_wdata[7:0]}} :
                         w_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;

    bram_sp_be #(.DEPTH(DEPTH_WORDS)) u_bram (
        .clk    (clk),
        .i_en   (w_bram_en),
        .i_be   (w_bram_be),
        .i_addr (w_bram_addr),
        .i_din  (w_bram_din),
        .o_dout (w_bram_dout)
    );

    assign w_lane = 16'(w_bram_dout >> {r_s1_off, 3'b000});
    assign w_ext  = r_s1_size == SZ_WORD ? w_bram_dout :
                    r_s1_size == SZ_HALF ? {{16{~r_s1_uns & w_lane[15]}}, w_lane[15:0]} :
                                           {{24{~r_s1_uns & w_lane[7]}}, w_lane[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_load   <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_uns    <= 1'b0;
            r_s1_size   <= SZ_BYTE;
            r_s1_off    <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_s1_valid  <= w_accept;
            r_s1_load   <= w_accept && !req_we && !w_err;
            r_s1_err    <= w_accept && w_err;
            r_s1_uns    <= w_accept && req_unsigned;
            r_s1_size   <= w_accept ? w_size : SZ_BYTE;
            r_s1_off    <= w_accept ? req_addr[1:0] : 2'b00;
            r_rsp_valid <= r_s1_valid;
            r_rsp_err   <= r_s1_err;
            r_rsp_rdata <= r_s1_load ? w_ext : '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words (power of two, 64..16384).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the memory after reset.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  in  1  meaning a request is presented.
REQ-007 SHALL have port req_ready  out  1  meaning the block accepts a request this cycle.
REQ-008 SHALL have port req_we  in  1  meaning 1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  meaning 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned  in  1  meaning zero-extend a load (LBU/LHU); ignored for word loads and stores.
REQ-011 SHALL have port req_addr  in  ADDR_W  meaning byte address.
REQ-012 SHALL have port req_wdata  in  32  meaning store data, right-justified (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port rsp_valid  out  1  meaning response available, single-cycle pulse, no backpressure.
REQ-014 SHALL have port rsp_rdata  out  32  meaning extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  meaning misaligned, out-of-range or illegal-size request.

Function
REQ-016 SHALL accept a request when req_valid && req_ready; at most one per cycle.
REQ-017 SHALL have FSM states CLEAR and READY; req_ready = 1 only in READY.
REQ-018 SHALL, in CLEAR, write 0 to word clr_cnt each cycle, clr_cnt from 0 to DEPTH_WORDS-1, then enter READY; CLEAR_ON_RESET=0 enters READY directly.
REQ-019 SHALL produce rsp_valid exactly 2 cycles after acceptance (cycle N -> N+2), for loads, stores and errors, in request order; back-to-back accepts give back-to-back responses.
REQ-020 SHALL, for a store, write only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all) at the edge ending cycle N.
REQ-021 SHALL, for a load, select lane(s) by addr[1:0] and sign-extend from bit 7/15 unless req_unsigned; word loads are unmodified.
REQ-022 SHALL flag rsp_err=1 and suppress the memory access when: half with addr[0]=1; word with addr[1:0]!=0; req_size=11; addr >= 4*DEPTH_WORDS.
REQ-023 SHALL use word index addr[$clog2(DEPTH_WORDS)+1:2].
REQ-024 SHALL return the new data for a load accepted in the cycle after a store to the same word.
REQ-025 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid=0.
REQ-026 SHALL not pass the ignored req_* inputs through when req_valid=0 or req_ready=0.

Reset
REQ-027 SHALL, on rst_n low at any time, immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear both pipeline valid bits, and set FSM=CLEAR (or READY if CLEAR_ON_RESET=0), clr_cnt=0.
REQ-028 SHALL drop in-flight requests at reset mid-operation without producing a response; memory contents other than the CLEAR pass are undefined.
REQ-029 SHALL have the first req_ready=1 at cycle DEPTH_WORDS after rst_n release when CLEAR_ON_RESET=1.

Structure
REQ-030 SHALL take size encodings (enum mem_size_e), LOAD_LATENCY=2 and the FSM state enum from package data_mem_pkg.
REQ-031 SHALL instantiate one sub-module bram_sp_be: single-port 32-bit, 4 byte-enable, registered-read array inferred as block RAM.
REQ-032 SHALL keep alignment/extension and error logic in data_mem_lsu, registered in pipeline stage 2.

Verification
REQ-033 SHALL cover: DEPTH_WORDS=64 reset release -> req_ready low 64 cycles, then high; LW 0x0..0xFC all read 0x00000000.
REQ-034 SHALL cover: SW 0x8=0xCAFEBABE, SB 0x9=0x00000080, LB 0x9 -> 0xFFFFFF80, LBU 0x9 -> 0x00000080, LW 0x8 -> 0xCAFE80BE.
REQ-035 SHALL cover: SH 0x12=0x00008001, LH 0x12 -> 0xFFFF8001, LHU 0x12 -> 0x00008001, LW 0x10 -> 0x80010000.
REQ-036 SHALL cover: LW 0x6, LH 0x3, size=11 at 0x0, LW 0x100 (DEPTH=64) -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-037 SHALL cover: SW 0x20=0xDEADBEEF cycle N, LW 0x20 cycle N+1 -> rsp at N+3 = 0xDEADBEEF; streaming 8 loads -> 8 consecutive rsp_valid.
REQ-038 SHALL cover: rst_n asserted one cycle after a load accept -> no rsp_valid, outputs 0 immediately, CLEAR restarts at clr_cnt=0.
